// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 state encoding, constants and round helpers
package aes_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_ADD_KEY,
    S_ENCRYPT_ROUNDS,
    S_FINAL_ROUND,
    S_DONE
  } aes_state_e;

  localparam int NUM_ROUNDS = 10;

  // Indexed by the round counter; entries past round 10 are never used.
  localparam logic [7:0] RCON [16] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k lives at [127-8k -: 8]; column c holds bytes 4c..4c+3, row = k % 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_128_encrypt_if.sv
// rtl/aes_128_encrypt_if.sv - start/plaintext/key request and ciphertext/done response bundle
interface aes_128_encrypt_if;
  logic         start_encrypt;
  logic [127:0] plaintext_in;
  logic [127:0] key_in;
  logic [127:0] ciphertext_out;
  logic         encrypt_done;

  modport master (output start_encrypt, plaintext_in, key_in,
                  input  ciphertext_out, encrypt_done);
  modport slave  (input  start_encrypt, plaintext_in, key_in,
                  output ciphertext_out, encrypt_done);
endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational 8-bit forward AES S-box
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign out_o = SBOX[in_i];
endmodule

// File: rtl/aes_128_encrypt.sv
// rtl/aes_128_encrypt.sv - iterative one-round-per-cycle AES-128 encryptor; AES_BUSY_OUT_EN adds a busy output
module aes_128_encrypt
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  aes_128_encrypt_if.slave   bus
`ifdef AES_BUSY_OUT_EN
  ,
  output logic               busy
`endif
);

  aes_state_e   state, state_d;
  logic [3:0]   round_counter, round_counter_d;
  logic [127:0] state_reg, state_reg_d;
  logic [127:0] current_round_key, round_key_d;
  logic [127:0] ciphertext_q, ciphertext_d;
  logic         encrypt_done_q, encrypt_done_d;
  logic         start_armed_q;

  logic [127:0] sub_bytes_w;
  logic [31:0]  sub_word_w;
  logic [31:0]  rot_word_w;
  logic [31:0]  ks_temp_w;
  logic [127:0] next_round_key_w;

  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (.in_i(state_reg[127-8*i -: 8]), .out_o(sub_bytes_w[127-8*i -: 8]));
  end

  assign rot_word_w = {current_round_key[23:0], current_round_key[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sub_word
    aes_sbox u_sbox (.in_i(rot_word_w[31-8*i -: 8]), .out_o(sub_word_w[31-8*i -: 8]));
  end

  // Next key word chain: each word folds in the freshly generated word to its left.
  assign ks_temp_w = sub_word_w ^ {RCON[round_counter], 24'h0};
  assign next_round_key_w[127:96] = current_round_key[127:96] ^ ks_temp_w;
  assign next_round_key_w[95:64]  = current_round_key[95:64]  ^ next_round_key_w[127:96];
  assign next_round_key_w[63:32]  = current_round_key[63:32]  ^ next_round_key_w[95:64];
  assign next_round_key_w[31:0]   = current_round_key[31:0]   ^ next_round_key_w[63:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      round_counter     <= '0;
      state_reg         <= '0;
      current_round_key <= '0;
      ciphertext_q      <= '0;
      encrypt_done_q    <= 1'b0;
      start_armed_q     <= 1'b0;
    end else begin
      state             <= state_d;
      round_counter     <= round_counter_d;
      state_reg         <= state_reg_d;
      current_round_key <= round_key_d;
      ciphertext_q      <= ciphertext_d;
      encrypt_done_q    <= encrypt_done_d;
      start_armed_q     <= 1'b1;
    end
  end

  // start_armed_q masks a start coinciding with the first edge after reset release.
  always_comb begin
    state_d         = state;
    round_counter_d = round_counter;
    state_reg_d     = state_reg;
    round_key_d     = current_round_key;
    ciphertext_d    = ciphertext_q;
    encrypt_done_d  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start_encrypt && start_armed_q) begin
          state_reg_d     = bus.plaintext_in;
          round_key_d     = bus.key_in;
          round_counter_d = 4'd0;
          state_d         = S_INIT_ADD_KEY;
        end
      end
      S_INIT_ADD_KEY: begin
        state_reg_d     = state_reg ^ current_round_key;
        round_key_d     = next_round_key_w;
        round_counter_d = 4'd1;
        state_d         = S_ENCRYPT_ROUNDS;
      end
      S_ENCRYPT_ROUNDS: begin
        state_reg_d     = mix_columns(shift_rows(sub_bytes_w)) ^ current_round_key;
        round_key_d     = next_round_key_w;
        round_counter_d = round_counter + 4'd1;
        if (round_counter == 4'(NUM_ROUNDS - 1))
          state_d = S_FINAL_ROUND;
      end
      S_FINAL_ROUND: begin
        ciphertext_d   = shift_rows(sub_bytes_w) ^ current_round_key;
        encrypt_done_d = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ciphertext_out = ciphertext_q;
  assign bus.encrypt_done   = encrypt_done_q;

`ifdef AES_BUSY_OUT_EN
  assign busy = (state != S_IDLE);
`endif

endmodule

// File: tb/tb_aes_128_encrypt.sv
// tb/tb_aes_128_encrypt.sv - scoreboard bench for aes_128_encrypt with a byte-level AES reference model
module tb_aes_128_encrypt;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_128_encrypt_if bus();
`ifdef AES_BUSY_OUT_EN
  logic busy;
  aes_128_encrypt dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));
`else
  aes_128_encrypt dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct { logic [127:0] ct; int cyc; } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] sbox_m [256];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} >> (8 - n);
    return d[7:0];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox_m[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = t[k] ^ w[4*rnd + k/4][31-8*(k%4) -: 8];
    end
    out = '0;
    for (int k = 0; k < 16; k++) out[127-8*k -: 8] = s[k];
    return out;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] exp_ct,
                           input bit whitebox, input bit scramble, input bit poke);
    int  n;
    bit  seen;
    @(negedge clk);
    bus.key_in = key; bus.plaintext_in = pt; bus.start_encrypt = 1'b1;
    n = cyc;
    exp_q.push_back('{exp_ct, n});
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      bus.start_encrypt = 1'b0;
      if (scramble && k == 1) begin bus.key_in = rand128(); bus.plaintext_in = rand128(); end
      if (poke && k == 5) bus.start_encrypt = 1'b1;
      if (whitebox && k == 2) begin
        chk("r1_state", 128'(dut.state), 128'(S_ENCRYPT_ROUNDS));
        chk("r1_counter", 128'(dut.round_counter), 128'd1);
        chk("r1_state_reg", dut.state_reg, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        chk("r1_round_key", dut.current_round_key, 128'ha0fafe1788542cb123a339392a6c7605);
      end
      if (whitebox && k == 10) begin
        chk("r9_state_reg", dut.state_reg, 128'hea835cf00445332d655d98ad8596b0c5);
        chk("r9_round_key", dut.current_round_key, 128'hac7766f319fadc2128d12941575c006e);
      end
      if (whitebox && k == 11) begin
        chk("r10_state", 128'(dut.state), 128'(S_FINAL_ROUND));
        chk("r10_counter", 128'(dut.round_counter), 128'd10);
        chk("r10_state_reg", dut.state_reg, 128'heb40f21e592e38848ba113e71bc342d2);
        chk("r10_round_key", dut.current_round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      end
      if (bus.encrypt_done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no encrypt_done within 20 cycles expected one (start cycle %0d)", n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, p, last_ct;
    int n;
    rst = 1'b1;
    bus.start_encrypt = 1'b0; bus.key_in = '0; bus.plaintext_in = '0;
    build_sbox();

    fork
      forever begin : monitor
        exp_t e;
        @(negedge clk);
        if (bus.encrypt_done === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got encrypt_done=1 at cycle %0d expected no pulse", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("ciphertext", bus.ciphertext_out, e.ct);
            chk("done_latency", 128'(cyc - e.cyc), 128'd12);
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_state", 128'(dut.state), 128'(S_IDLE));
    chk("rst_counter", 128'(dut.round_counter), 128'd0);
    chk("rst_state_reg", dut.state_reg, 128'd0);
    chk("rst_round_key", dut.current_round_key, 128'd0);
    chk("rst_ciphertext", bus.ciphertext_out, 128'd0);
    chk("rst_done", 128'(bus.encrypt_done), 128'd0);
    rst = 1'b0;

    run_block(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32, 1'b1, 1'b0, 1'b0);
    run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b1, 1'b1);

    last_ct = '0;
    for (int i = 0; i < 6; i++) begin
      k = rand128(); p = rand128();
      last_ct = aes_ref(k, p);
      run_block(k, p, last_ct, 1'b0, (i % 2) == 0, (i % 3) == 1);
    end
    repeat (5) @(negedge clk);
    chk("ciphertext_hold", bus.ciphertext_out, last_ct);

    @(negedge clk);
    bus.key_in = rand128(); bus.plaintext_in = rand128(); bus.start_encrypt = 1'b1;
    n = cyc;
    @(negedge clk);
    bus.start_encrypt = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_state", 128'(dut.state), 128'(S_ENCRYPT_ROUNDS));
    chk("mid_counter", 128'(dut.round_counter), 128'd5);
    chk("mid_cycle", 128'(cyc - n), 128'd6);
    rst = 1'b1;
    #1;
    chk("abort_state", 128'(dut.state), 128'(S_IDLE));
    chk("abort_ciphertext", bus.ciphertext_out, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.start_encrypt = 1'b1;
    @(negedge clk);
    bus.start_encrypt = 1'b0;
    repeat (20) @(negedge clk);
    chk("release_start_ignored", 128'(dut.state), 128'(S_IDLE));
    chk("abort_ciphertext_kept", bus.ciphertext_out, 128'd0);

    k = rand128(); p = rand128();
    run_block(k, p, aes_ref(k, p), 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
